sync_fifo_param: RTL

Parametrised synchronous FIFO, the successor to the current fixed 8x8 syn_FIFO. It adds the following:
- arbitrary (non-power-of-2) depth
- occupancy count
- programmable almost-full and almost-empty thresholds
- a selectable first-word-fall-through (FWFT) read mode
- sticky overflow and underflow error flags

It is the generic single-clock buffer between producer and consumer datapaths.

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 24 ++
 rtl/sync_fifo_param.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helper for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2. Used to size the pointers (DEPTH) and the occupancy count (DEPTH+1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage. Writes are synchronous and reads are asynchronous by address.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Storage is never reset, so contents are only defined once they have been written.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO. It supports any depth, an occupancy count, almost-full and
// almost-empty thresholds, standard or first-word-fall-through reads, and sticky error flags.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FIFO_MODE_STD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_en,
    input  logic [WIDTH-1:0]            w_data,
    input  logic                        r_en,
    output logic [WIDTH-1:0]            r_data,
    output logic                        r_valid,
    output logic                        isFull,
    output logic                        isEmpty,
    output logic                        isAlmostFull,
    output logic                        isAlmostEmpty,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        err_clr
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    if (DEPTH < 2 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_params
        $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             afull_q, afull_d, aempty_q, aempty_d;
    logic [WIDTH-1:0] r_data_q, r_data_d;
    logic             r_valid_q, r_valid_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             rd_acc, wr_acc;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    // Pointers wrap by explicit compare, so any depth works.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Accept, pointer, count, flag, read-data and error-flag next-state logic.
    always_comb begin
        rd_acc    = r_en & ~empty_q;
        // A full FIFO can still take a write when a read frees a slot in the same cycle.
        wr_acc    = w_en & (~full_q | rd_acc);

        wr_ptr_d  = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q + CW'(wr_acc) - CW'(rd_acc);

        empty_d   = (count_d == '0);
        full_d    = (count_d == CW'(DEPTH));
        afull_d   = (count_d >= CW'(AF_LEVEL));
        aempty_d  = (count_d <= CW'(AE_LEVEL));

        // FWFT registers the head that will exist after this edge. Standard mode registers the current head on a pop.
        mem_raddr = (FWFT == FIFO_MODE_FWFT) ? rd_ptr_d : rd_ptr_q;
        r_data_d  = r_data_q;
        if (FWFT == FIFO_MODE_FWFT) begin
            r_valid_d = (count_d != '0);
            if (count_d != '0) begin
                // The new head may be the word that is being written this cycle and is not yet in storage.
                r_data_d = (wr_acc && (rd_ptr_d == wr_ptr_q)) ? w_data : mem_rdata;
            end
        end else begin
            r_valid_d = rd_acc;
            if (rd_acc) r_data_d = mem_rdata;
        end

        // A new error in the same cycle as err_clr still sets the flag.
        ovf_d     = (ovf_q & ~err_clr) | (w_en & ~wr_acc);
        unf_d     = (unf_q & ~err_clr) | (r_en & ~rd_acc);
    end

    // State registers. Reset overrides every request that arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q),
        .wdata (w_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign r_data        = r_data_q;
    assign r_valid       = r_valid_q;
    assign isFull        = full_q;
    assign isEmpty       = empty_q;
    assign isAlmostFull  = afull_q;
    assign isAlmostEmpty = aempty_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

endmodule
